// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM arbiter: default bus widths and FSM state encoding.
package sram_pkg;

  localparam int DEF_ADDR_W = 20;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side and controller-side signal bundle of the SRAM arbiter.
`default_nettype none
interface sram_arbiter_if
  import sram_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req0, req1, we0, we1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [DATA_W-1:0] wdata0, wdata1;
  logic [DATA_W-1:0] rdata0, rdata1;
  logic              done0, done1, err0, err1;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              mem_done;
  logic              busy, owner;

  // Arbiter side
  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_done,
    output rdata0, rdata1, done0, done1, err0, err1,
           mem_read, mem_write, mem_addr, mem_wdata, busy, owner
  );

  // Requester/controller side
  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata, mem_done,
    input  rdata0, rdata1, done0, done1, err0, err1,
           mem_read, mem_write, mem_addr, mem_wdata, busy, owner
  );
endinterface
`default_nettype wire

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port that did not win last.
`default_nettype none
module rr_arb2 (
  input  wire logic [1:0] req_i,
  input  wire logic       last_owner_i,
  output logic            gnt_o,
  output logic            valid_o
);
  assign valid_o = |req_i;
  assign gnt_o   = (req_i == 2'b11) ? ~last_owner_i : req_i[1];
endmodule
`default_nettype wire

// File: rtl/sram_arbiter.sv
// Shares one SRAM controller strobe interface between two requesters with a per-access timeout.
`default_nettype none
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 1023
) (
  input  wire logic      clk,
  input  wire logic      rst_n,
  sram_arbiter_if.slave  bus
);
  localparam int          TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] C_TLAST = TW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic              abort_q, abort_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic              arb_gnt, arb_valid;

  rr_arb2 u_arb (
    .req_i        ({bus.req1, bus.req0}),
    .last_owner_i (last_q),
    .gnt_o        (arb_gnt),
    .valid_o      (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      timer_q  <= '0;
      abort_q  <= 1'b0;
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      abort_q  <= abort_d;
      owner_q  <= owner_d;
      last_q   <= last_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    abort_d  = abort_q;
    owner_d  = owner_q;
    last_d   = last_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          owner_d = arb_gnt;
          last_d  = arb_gnt;
          we_d    = arb_gnt ? bus.we1    : bus.we0;
          addr_d  = arb_gnt ? bus.addr1  : bus.addr0;
          wdata_d = arb_gnt ? bus.wdata1 : bus.wdata0;
          timer_d = '0;
          abort_d = 1'b0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // Completion takes precedence over a timeout on the same edge.
        if (bus.mem_done) begin
          if (!we_q) begin
            if (owner_q) rdata1_d = bus.mem_rdata;
            else         rdata0_d = bus.mem_rdata;
          end
          state_d = ST_DONE;
        end else if (timer_q == C_TLAST) begin
          abort_d = 1'b1;
          state_d = ST_DONE;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobes and pulses decode straight from state so an async reset drops them at once.
  assign bus.mem_read  = (state_q == ST_ISSUE) && !we_q;
  assign bus.mem_write = (state_q == ST_ISSUE) &&  we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.done0     = (state_q == ST_DONE) && !abort_q && !owner_q;
  assign bus.done1     = (state_q == ST_DONE) && !abort_q &&  owner_q;
  assign bus.err0      = (state_q == ST_DONE) &&  abort_q && !owner_q;
  assign bus.err1      = (state_q == ST_DONE) &&  abort_q &&  owner_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.busy      = (state_q == ST_ISSUE) || (state_q == ST_DONE);
  assign bus.owner     = owner_q;
endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed accesses, contention, timeout and async reset.
`default_nettype none
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 32;
  localparam int TO = 8;

  typedef struct {
    int          port;
    bit          we;
    logic [19:0] addr;
    logic [31:0] wd;
    bit          is_err;
    logic [31:0] rd;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          resp_delay = 0;
  bit          resp_xor   = 1'b0;
  bit          stray      = 1'b0;
  logic [31:0] resp_data  = '0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic push(int port, bit we, logic [19:0] addr, logic [31:0] wd,
                      bit is_err, logic [31:0] rd, int cyc);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.wd = wd;
    e.is_err = is_err; e.rd = rd; e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic set_port(int port, bit req, bit we, logic [19:0] addr, logic [31:0] wd);
    if (port == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = addr; bus.wdata0 = wd;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = addr; bus.wdata1 = wd;
    end
  endtask

  task automatic wait_pulse(int port);
    bit seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (port == 0) seen = bus.done0 | bus.err0;
      else           seen = bus.done1 | bus.err1;
    end
    if (!seen) check($sformatf("wait_pulse%0d_timeout", port), 32'd0, 32'd1);
  endtask

  task automatic single(int port, bit we, logic [19:0] addr, logic [31:0] wd, int delay,
                        bit is_err, logic [31:0] rd, int cyc);
    resp_delay = delay;
    push(port, we, addr, wd, is_err, rd, cyc);
    set_port(port, 1'b1, we, addr, wd);
    wait_pulse(port);
    set_port(port, 1'b0, 1'b0, '0, '0);
  endtask

  // Controller model: mem_done in the delay-th strobe cycle (0 = never), or always when stray.
  initial begin : responder
    int k;
    k = 0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_read || bus.mem_write) k++;
      else k = 0;
      bus.mem_done  = stray || (k != 0 && k == resp_delay);
      bus.mem_rdata = resp_xor ? (resp_data ^ {12'h000, bus.mem_addr}) : resp_data;
    end
  end

  initial begin : monitor
    exp_t        h;
    int          cnt;
    bit          prev, strobe;
    logic [3:0]  pulses, exp_p;
    logic [31:0] exp_rd0, exp_rd1;
    cnt = 0; prev = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        sb.delete();
        cnt = 0; prev = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
      end else begin
        strobe = bus.mem_read | bus.mem_write;
        if (strobe && !prev) begin
          if (sb.size() == 0) check("strobe_unexpected", 32'd1, 32'd0);
          else begin
            h = sb[0];
            check("strobe_mode", {30'd0, bus.mem_write, bus.mem_read}, h.we ? 32'd2 : 32'd1);
            check("mem_addr", {12'h000, bus.mem_addr}, {12'h000, h.addr});
            if (h.we) check("mem_wdata", bus.mem_wdata, h.wd);
            check("owner", {31'd0, bus.owner}, h.port);
          end
        end
        if (strobe) cnt++;
        pulses = {bus.err1, bus.err0, bus.done1, bus.done0};
        if (pulses != 4'd0) begin
          if (sb.size() == 0) check("pulse_unexpected", {28'd0, pulses}, 32'd0);
          else begin
            h = sb.pop_front();
            exp_p = h.is_err ? (h.port != 0 ? 4'b1000 : 4'b0100)
                             : (h.port != 0 ? 4'b0010 : 4'b0001);
            check("pulse", {28'd0, pulses}, {28'd0, exp_p});
            check("strobe_cycles", cnt, h.cyc);
            check("strobe_low_at_pulse", {31'd0, strobe}, 32'd0);
            if (!h.is_err && !h.we) begin
              if (h.port != 0) exp_rd1 = h.rd;
              else             exp_rd0 = h.rd;
            end
            check("rdata0", bus.rdata0, exp_rd0);
            check("rdata1", bus.rdata1, exp_rd1);
          end
          cnt = 0;
        end
        prev = strobe;
      end
    end
  end

  task automatic check_idle_outputs(string tag);
    check({tag, "_strobes"}, {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    check({tag, "_pulses"}, {28'd0, bus.err1, bus.err0, bus.done1, bus.done0}, 32'd0);
    check({tag, "_busy"}, {31'd0, bus.busy}, 32'd0);
    check({tag, "_owner"}, {31'd0, bus.owner}, 32'd0);
    check({tag, "_rdata0"}, bus.rdata0, 32'd0);
    check({tag, "_rdata1"}, bus.rdata1, 32'd0);
  endtask

  initial begin : main
    set_port(0, 1'b0, 1'b0, '0, '0);
    set_port(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset");

    single(0, 1'b1, 20'h00000, 32'h5, 4, 1'b0, '0, 4);
    resp_data = 32'hDEADBEEF;
    single(1, 1'b0, 20'h0ABCD, '0, 2, 1'b0, 32'hDEADBEEF, 2);

    // Both held: grants must alternate 0,1,0,1.
    resp_delay = 1; resp_xor = 1'b1; resp_data = 32'hA5000000;
    push(0, 1'b1, 20'h00010, 32'h11, 1'b0, '0, 1);
    push(1, 1'b0, 20'h00020, '0, 1'b0, 32'hA5000020, 1);
    push(0, 1'b0, 20'h00012, '0, 1'b0, 32'hA5000012, 1);
    push(1, 1'b1, 20'h00021, 32'h22, 1'b0, '0, 1);
    set_port(0, 1'b1, 1'b1, 20'h00010, 32'h11);
    set_port(1, 1'b1, 1'b0, 20'h00020, '0);
    wait_pulse(0); set_port(0, 1'b1, 1'b0, 20'h00012, '0);
    wait_pulse(1); set_port(1, 1'b1, 1'b1, 20'h00021, 32'h22);
    wait_pulse(0); set_port(0, 1'b0, 1'b0, '0, '0);
    wait_pulse(1); set_port(1, 1'b0, 1'b0, '0, '0);
    resp_xor = 1'b0;

    // mem_done stuck high: minimum 3-cycle access, ignored while idle.
    stray = 1'b1;
    single(1, 1'b1, 20'h00040, 32'h41, 0, 1'b0, '0, 1);
    repeat (3) @(negedge clk);
    check("stray_done_idle_busy", {31'd0, bus.busy}, 32'd0);
    stray = 1'b0;
    @(negedge clk);

    single(0, 1'b0, 20'h00050, '0, 0, 1'b1, '0, TO);
    resp_data = 32'h13572468;
    single(0, 1'b0, 20'h00051, '0, TO, 1'b0, 32'h13572468, TO);

    // Reset in the middle of a hanging read on port 0.
    resp_delay = 0;
    push(0, 1'b0, 20'h00030, '0, 1'b1, '0, TO);
    set_port(0, 1'b1, 1'b0, 20'h00030, '0);
    repeat (3) @(negedge clk);
    check("pre_reset_read", {31'd0, bus.mem_read}, 32'd1);
    #2 rst_n = 1'b0;
    #1 check("async_reset_strobes", {30'd0, bus.mem_read, bus.mem_write}, 32'd0);
    set_port(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    resp_delay = 1;
    push(0, 1'b1, 20'h00060, 32'h61, 1'b0, '0, 1);
    push(1, 1'b1, 20'h00070, 32'h71, 1'b0, '0, 1);
    set_port(0, 1'b1, 1'b1, 20'h00060, 32'h61);
    set_port(1, 1'b1, 1'b1, 20'h00070, 32'h71);
    wait_pulse(0); set_port(0, 1'b0, 1'b0, '0, '0);
    wait_pulse(1); set_port(1, 1'b0, 1'b0, '0, '0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end
endmodule
`default_nettype wire
